parking_gate_arbiter: RTL and testbench

- Controller for the lot's single shared barrier gate, serving an entry lane and an exit lane.
- Arbitrates the gate between the two lanes and runs the 2-bit password check on entry, with an attempt limit and lockout.
- Tracks lot occupancy against capacity.
- Sits between the lane sensors/keypad and the gate actuator.

---
 rtl/parking_gate_arbiter_pkg.sv | 25 ++
 rtl/parking_gate_arbiter_if.sv | 30 +++
 rtl/parking_gate_arbiter_gate_timer.sv | 28 ++
 rtl/parking_gate_arbiter.sv | 152 +++++++++++++++
 tb/tb_parking_gate_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/parking_gate_arbiter_pkg.sv
// Shared types and default timing constants for the parking gate arbiter.
package parking_gate_arbiter_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_PW,
      OPEN_ENTRY,
      OPEN_EXIT,
      LOCKOUT
   } state_e;

   typedef enum logic {
      ENTRY,
      EXIT
   } lane_e;

   localparam int unsigned DEF_CAPACITY    = 8;
   localparam int unsigned DEF_PW_CYCLES   = 32;
   localparam int unsigned DEF_OPEN_CYCLES = 16;
   localparam int unsigned DEF_LOCK_CYCLES = 64;

   // Wide enough for the longest timeout (lockout).
   localparam int unsigned TMR_W = 8;

endpackage

// File: rtl/parking_gate_arbiter_if.sv
// Lane sensor / keypad / gate actuator bundle for the parking gate arbiter.
interface parking_gate_arbiter_if #(
   parameter int unsigned CNT_W = 4
);
   logic             entry_req;
   logic             exit_req;
   logic             pw_valid;
   logic [1:0]       pw_data;
   logic             car_passed;
   logic             gate_open;
   logic             grant_entry;
   logic             grant_exit;
   logic             pw_wrong;
   logic             locked;
   logic             full;
   logic [CNT_W-1:0] occupancy;
   logic [1:0]       tries_left;

   // Sensor/keypad side.
   modport master (
      output entry_req, exit_req, pw_valid, pw_data, car_passed,
      input  gate_open, grant_entry, grant_exit, pw_wrong, locked, full, occupancy, tries_left
   );

   // Arbiter side.
   modport slave (
      input  entry_req, exit_req, pw_valid, pw_data, car_passed,
      output gate_open, grant_entry, grant_exit, pw_wrong, locked, full, occupancy, tries_left
   );
endinterface

// File: rtl/parking_gate_arbiter_gate_timer.sv
// Clear/enable up-counter with a compare-to-limit flag, shared by all timed states.
module parking_gate_arbiter_gate_timer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] limit,
   output logic             done
);

   logic [WIDTH-1:0] count_q;

   // Count up while enabled; clear takes priority so each state starts at zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (enable) begin
         count_q <= count_q + WIDTH'(1);
      end
   end

   assign done = (count_q == limit);

endmodule

// File: rtl/parking_gate_arbiter.sv
// Shared barrier gate controller: lane arbitration, entry password check with
// lockout, and occupancy tracking.
module parking_gate_arbiter
   import parking_gate_arbiter_pkg::*;
#(
   parameter int unsigned CAPACITY    = DEF_CAPACITY,
   parameter int unsigned CNT_W       = 4,
   parameter logic [1:0]  PASSWORD    = 2'b01,
   parameter int unsigned MAX_TRIES   = 3,
   parameter int unsigned PW_CYCLES   = DEF_PW_CYCLES,
   parameter int unsigned OPEN_CYCLES = DEF_OPEN_CYCLES,
   parameter int unsigned LOCK_CYCLES = DEF_LOCK_CYCLES
) (
   input logic                   clk,
   input logic                   reset,
   parking_gate_arbiter_if.slave bus
);

   state_e           state_q, state_d;
   lane_e            last_served_q, last_served_d;
   logic [CNT_W-1:0] occupancy_q, occupancy_d;
   logic [1:0]       tries_q, tries_d;
   logic             pw_wrong_q, pw_wrong_d;

   logic             full, entry_ok, exit_ok, pick_exit;
   logic             tmr_restart, tmr_clear, tmr_enable, tmr_done;
   logic [TMR_W-1:0] tmr_limit;

   assign full     = (occupancy_q == CNT_W'(CAPACITY));
   assign entry_ok = bus.entry_req && !full;
   assign exit_ok  = bus.exit_req && (occupancy_q != '0);
   // On a tie the lane not served last wins.
   assign pick_exit = exit_ok && (!entry_ok || (last_served_q == ENTRY));

   // Select the timeout for the current state.
   always_comb begin
      tmr_limit = '0;
      case (state_q)
         WAIT_PW:              tmr_limit = TMR_W'(PW_CYCLES - 1);
         OPEN_ENTRY, OPEN_EXIT: tmr_limit = TMR_W'(OPEN_CYCLES - 1);
         LOCKOUT:              tmr_limit = TMR_W'(LOCK_CYCLES - 1);
         default:              tmr_limit = '0;
      endcase
   end

   assign tmr_clear  = (state_d != state_q) || tmr_restart;
   assign tmr_enable = (state_q != IDLE);

   parking_gate_arbiter_gate_timer #(
      .WIDTH(TMR_W)
   ) u_gate_timer (
      .clk   (clk),
      .reset (reset),
      .clear (tmr_clear),
      .enable(tmr_enable),
      .limit (tmr_limit),
      .done  (tmr_done)
   );

   // Next-state, occupancy, attempt and round-robin bookkeeping.
   always_comb begin
      state_d       = state_q;
      last_served_d = last_served_q;
      occupancy_d   = occupancy_q;
      tries_d       = tries_q;
      pw_wrong_d    = 1'b0;
      tmr_restart   = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_exit) begin
               state_d       = OPEN_EXIT;
               last_served_d = EXIT;
            end else if (entry_ok) begin
               state_d       = WAIT_PW;
               last_served_d = ENTRY;
               tries_d       = 2'(MAX_TRIES);
            end
         end
         WAIT_PW: begin
            if (bus.pw_valid) begin
               if (bus.pw_data == PASSWORD) begin
                  state_d = OPEN_ENTRY;
               end else begin
                  pw_wrong_d  = 1'b1;
                  tries_d     = tries_q - 2'd1;
                  tmr_restart = 1'b1;
                  if (tries_q == 2'd1) begin
                     state_d = LOCKOUT;
                  end
               end
            end else if (!bus.entry_req || tmr_done) begin
               state_d = IDLE;
            end
         end
         OPEN_ENTRY: begin
            if (bus.car_passed) begin
               occupancy_d = occupancy_q + CNT_W'(1);
               state_d     = IDLE;
            end else if (tmr_done) begin
               state_d = IDLE;
            end
         end
         OPEN_EXIT: begin
            if (bus.car_passed) begin
               if (occupancy_q != '0) begin
                  occupancy_d = occupancy_q - CNT_W'(1);
               end
               state_d = IDLE;
            end else if (tmr_done) begin
               state_d = IDLE;
            end
         end
         LOCKOUT: begin
            if (tmr_done) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and bookkeeping registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         last_served_q <= ENTRY;
         occupancy_q   <= '0;
         tries_q       <= '0;
         pw_wrong_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_served_q <= last_served_d;
         occupancy_q   <= occupancy_d;
         tries_q       <= tries_d;
         pw_wrong_q    <= pw_wrong_d;
      end
   end

   assign bus.gate_open   = (state_q == OPEN_ENTRY) || (state_q == OPEN_EXIT);
   assign bus.grant_entry = (state_q == OPEN_ENTRY);
   assign bus.grant_exit  = (state_q == OPEN_EXIT);
   assign bus.pw_wrong    = pw_wrong_q;
   assign bus.locked      = (state_q == LOCKOUT);
   assign bus.full        = full;
   assign bus.occupancy   = occupancy_q;
   assign bus.tries_left  = (state_q == WAIT_PW) ? tries_q : 2'd0;

   // An exit from an empty lot would mean the occupancy bookkeeping has broken.
   assert property (@(posedge clk) disable iff (reset)
      !((state_q == OPEN_EXIT) && bus.car_passed && (occupancy_q == '0)));

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed self-checking bench for parking_gate_arbiter.
module tb_parking_gate_arbiter;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_pass;

   parking_gate_arbiter_if #(.CNT_W(4)) bus ();

   parking_gate_arbiter dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Advance n rising edges, then settle just after the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.entry_req  = 1'b0;
      bus.exit_req   = 1'b0;
      bus.pw_valid   = 1'b0;
      bus.pw_data    = 2'b00;
      bus.car_passed = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      #3;
      check("rst_gate_open", 32'(bus.gate_open), 0);
      check("rst_occupancy", 32'(bus.occupancy), 0);
      check("rst_locked", 32'(bus.locked), 0);
      check("rst_tries_left", 32'(bus.tries_left), 0);
      @(negedge clk);
      reset = 1'b0;
      tick(1);
   endtask

   task automatic enter_car();
      bus.entry_req = 1'b1;
      tick(1);
      bus.pw_valid = 1'b1;
      bus.pw_data  = 2'b01;
      tick(1);
      bus.pw_valid   = 1'b0;
      bus.entry_req  = 1'b0;
      bus.car_passed = 1'b1;
      tick(1);
      bus.car_passed = 1'b0;
   endtask

   task automatic exit_car();
      bus.exit_req = 1'b1;
      tick(1);
      bus.exit_req   = 1'b0;
      bus.car_passed = 1'b1;
      tick(1);
      bus.car_passed = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      reset    = 1'b0;
      clear_inputs();

      // 1: normal entry
      do_reset();
      check("t1_full_after_reset", 32'(bus.full), 0);
      bus.entry_req = 1'b1;
      tick(1);
      check("t1_tries_start", 32'(bus.tries_left), 3);
      check("t1_gate_closed_wait", 32'(bus.gate_open), 0);
      bus.pw_valid = 1'b1;
      bus.pw_data  = 2'b01;
      tick(1);
      bus.pw_valid = 1'b0;
      check("t1_gate_open", 32'(bus.gate_open), 1);
      check("t1_grant_entry", 32'(bus.grant_entry), 1);
      bus.entry_req  = 1'b0;
      bus.car_passed = 1'b1;
      tick(1);
      bus.car_passed = 1'b0;
      check("t1_occupancy", 32'(bus.occupancy), 1);
      check("t1_gate_closed", 32'(bus.gate_open), 0);

      // 2: three wrong codes then lockout
      bus.entry_req = 1'b1;
      tick(1);
      for (int i = 0; i < 3; i++) begin
         bus.pw_valid = 1'b1;
         bus.pw_data  = 2'b00;
         tick(1);
         bus.pw_valid = 1'b0;
         check("t2_pw_wrong", 32'(bus.pw_wrong), 1);
         check("t2_tries_left", 32'(bus.tries_left), (i < 2) ? 32'(2 - i) : 32'd0);
      end
      check("t2_locked", 32'(bus.locked), 1);
      bus.pw_valid = 1'b1;
      bus.pw_data  = 2'b01;
      bus.exit_req = 1'b1;
      tick(1);
      bus.pw_valid = 1'b0;
      check("t2_pw_wrong_pulse_end", 32'(bus.pw_wrong), 0);
      check("t2_strobe_ignored", 32'(bus.gate_open), 0);
      tick(62);
      check("t2_locked_last_cycle", 32'(bus.locked), 1);
      check("t2_exit_blocked", 32'(bus.gate_open), 0);
      tick(1);
      check("t2_unlocked", 32'(bus.locked), 0);
      check("t2_idle_after_lock", 32'(bus.gate_open), 0);
      bus.entry_req = 1'b0;
      bus.exit_req  = 1'b0;
      tick(1);

      // 3: round-robin tie break
      do_reset();
      enter_car();
      enter_car();
      check("t3_occupancy2", 32'(bus.occupancy), 2);
      bus.entry_req = 1'b1;
      bus.exit_req  = 1'b1;
      tick(1);
      check("t3_tie1_exit", 32'(bus.grant_exit), 1);
      check("t3_tie1_no_entry", 32'(bus.grant_entry), 0);
      bus.entry_req  = 1'b0;
      bus.exit_req   = 1'b0;
      bus.car_passed = 1'b1;
      tick(1);
      bus.car_passed = 1'b0;
      check("t3_occupancy1", 32'(bus.occupancy), 1);
      bus.entry_req = 1'b1;
      bus.exit_req  = 1'b1;
      tick(1);
      check("t3_tie2_entry", 32'(bus.tries_left), 3);
      check("t3_tie2_no_exit", 32'(bus.grant_exit), 0);
      bus.entry_req = 1'b0;
      bus.exit_req  = 1'b0;
      tick(1);
      check("t3_drop_to_idle", 32'(bus.tries_left), 0);

      // 4: fill the lot
      for (int i = 0; i < 7; i++) enter_car();
      check("t4_occupancy8", 32'(bus.occupancy), 8);
      check("t4_full", 32'(bus.full), 1);
      bus.entry_req = 1'b1;
      tick(2);
      check("t4_no_grant_full", 32'(bus.tries_left), 0);
      check("t4_gate_closed_full", 32'(bus.gate_open), 0);
      bus.entry_req = 1'b0;
      exit_car();
      check("t4_occupancy7", 32'(bus.occupancy), 7);
      check("t4_not_full", 32'(bus.full), 0);

      // 5: empty the lot, then an exit request must be refused
      for (int i = 0; i < 7; i++) exit_car();
      check("t5_occupancy0", 32'(bus.occupancy), 0);
      bus.exit_req = 1'b1;
      tick(1);
      check("t5_no_exit_grant", 32'(bus.grant_exit), 0);
      tick(1);
      check("t5_gate_closed", 32'(bus.gate_open), 0);
      bus.exit_req = 1'b0;

      // gate-open timeout with no car
      bus.entry_req = 1'b1;
      tick(1);
      bus.pw_valid = 1'b1;
      bus.pw_data  = 2'b01;
      tick(1);
      bus.pw_valid  = 1'b0;
      bus.entry_req = 1'b0;
      tick(15);
      check("to_open_last_cycle", 32'(bus.gate_open), 1);
      tick(1);
      check("to_open_closed", 32'(bus.gate_open), 0);
      check("to_open_occupancy", 32'(bus.occupancy), 0);

      // 7: password timeout
      bus.entry_req = 1'b1;
      tick(1);
      tick(31);
      check("t7_wait_last_cycle", 32'(bus.tries_left), 3);
      tick(1);
      check("t7_timed_out", 32'(bus.tries_left), 0);
      check("t7_no_pw_wrong", 32'(bus.pw_wrong), 0);
      bus.entry_req = 1'b0;
      tick(1);

      // 6: async reset mid OPEN_ENTRY
      enter_car();
      bus.entry_req = 1'b1;
      tick(1);
      bus.pw_valid = 1'b1;
      bus.pw_data  = 2'b01;
      tick(1);
      bus.pw_valid = 1'b0;
      check("t6_gate_open", 32'(bus.gate_open), 1);
      check("t6_occupancy_before", 32'(bus.occupancy), 1);
      #2;
      reset = 1'b1;
      #1;
      check("t6_async_gate_drop", 32'(bus.gate_open), 0);
      check("t6_async_occupancy", 32'(bus.occupancy), 0);
      clear_inputs();
      @(negedge clk);
      reset = 1'b0;
      tick(1);
      check("t6_idle_gate", 32'(bus.gate_open), 0);
      check("t6_idle_occupancy", 32'(bus.occupancy), 0);
      check("t6_idle_tries", 32'(bus.tries_left), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
